stopwatch_ctrl: RTL and testbench

Front-end control stage for the seconds-counter display chain: debounces two active-low push-buttons and runs a start/stop/clear state machine. It drives the `enable` and `aclr` inputs of the downstream seconds counter. Raw `KEY` inputs enter here; `run` and `clr_n` leave here as clean, registered, glitch-free levels and pulses.

---
 rtl/stopwatch_ctrl.sv | 128 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end control for the seconds-counter display chain. Two raw, bouncy,
// active-low push-buttons are synchronized and debounced. An accepted press
// drives a start/stop/clear state machine. The state machine feeds the
// downstream counter's enable and asynchronous clear.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a synchronized key level must persist before it
//                     is accepted (>= 2). The default is 20 ms at 50 MHz.
//
// Ports
//   clk       in   system clock
//   aclr      in   asynchronous active-low reset
//   key_ss_n  in   raw start/stop button, active-low, asynchronous
//   key_clr_n in   raw clear button, active-low, asynchronous
//   run       out  registered counter enable, 1 only while RUNNING
//   clr_n     out  registered active-low clear, one-cycle low per clear press
//   state     out  FSM state for LEDs (IDLE=00, RUNNING=01, PAUSED=10)
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       key_ss_n,
    input  logic       key_clr_n,
    output logic       run,
    output logic       clr_n,
    output logic [1:0] state
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    // Channel 0 is start/stop, channel 1 is clear.
    logic [1:0] key_raw;
    logic [1:0] press_strobe;

    assign key_raw = {key_clr_n, key_ss_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic          sync1_reg;
            logic          sync_reg;
            logic          stable_reg;
            logic          strobe_reg;
            logic [CW-1:0] cnt_reg;

            // Idle level of a key is 1, so the flops reset to 1. A key that is
            // held through reset then looks like a fresh press.
            always_ff @(posedge clk or negedge aclr) begin
                if (!aclr) begin
                    sync1_reg  <= 1'b1;
                    sync_reg   <= 1'b1;
                    stable_reg <= 1'b1;
                    strobe_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync_reg  <= sync1_reg;

                    // The strobe fires only on an accepted 1->0 change. A
                    // release (0->1) updates stable but raises no strobe.
                    strobe_reg <= (sync_reg != stable_reg) && (cnt_reg == CNT_LAST)
                                  && stable_reg;

                    if (sync_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= sync_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign press_strobe[gi] = strobe_reg;
        end
    endgenerate

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       run_reg;
    logic       clr_n_reg;

    // Clear overrides start/stop in the same cycle. The start/stop strobe is
    // dropped, not held over.
    always_comb begin
        state_next = state_reg;
        if (press_strobe[1]) begin
            state_next = ST_IDLE;
        end else if (press_strobe[0]) begin
            case (state_reg)
                ST_IDLE:    state_next = ST_RUNNING;
                ST_RUNNING: state_next = ST_PAUSED;
                ST_PAUSED:  state_next = ST_RUNNING;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // run is registered from next state so that it changes on the same edge
    // as state.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_reg <= ST_IDLE;
            run_reg   <= 1'b0;
            clr_n_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            run_reg   <= (state_next == ST_RUNNING);
            clr_n_reg <= ~press_strobe[1];
        end
    end

    assign state = state_reg;
    assign run   = run_reg;
    assign clr_n = clr_n_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES = 4.
//
// A behavioural model is stepped on every clock edge. The model tracks how
// many consecutive raw samples differ from the accepted key level. When that
// run reaches D samples, the new level is accepted. An accepted press takes
// effect on the outputs three edges after its D-th sample. The bench compares
// the outputs against the model every cycle. It also makes directed checks
// against fixed constants at the key timing points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       aclr;
    logic       key_ss_n;
    logic       key_clr_n;
    logic       run;
    logic       clr_n;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    bit run_seen;

    // Reference model state: index 0 is start/stop, index 1 is clear.
    int         m_acc [2];   // accepted level of each key
    int         m_diff[2];   // consecutive raw samples differing from m_acc
    int         m_cd  [2];   // edges until an accepted press reaches outputs
    int         m_mode;      // 0 idle, 1 running, 2 paused
    logic       m_clr_n;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .key_ss_n  (key_ss_n),
        .key_clr_n (key_clr_n),
        .run       (run),
        .clr_n     (clr_n),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i]  = 1;
            m_diff[i] = 0;
            m_cd[i]   = -1;
        end
        m_mode  = 0;
        m_clr_n = 1'b1;
    endtask

    task automatic model_step();
        bit fire[2];
        int raw;
        if (!aclr) begin
            model_reset();
            return;
        end
        m_clr_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fire[i] = 1'b0;
            if (m_cd[i] > 0) begin
                m_cd[i]--;
                if (m_cd[i] == 0) begin
                    fire[i] = 1'b1;
                    m_cd[i] = -1;
                end
            end
        end
        if (fire[1]) begin
            m_mode  = 0;
            m_clr_n = 1'b0;
        end else if (fire[0]) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end
        for (int i = 0; i < 2; i++) begin
            raw = (i == 0) ? int'(key_ss_n) : int'(key_clr_n);
            if (raw != m_acc[i]) begin
                m_diff[i]++;
                if (m_diff[i] == D) begin
                    if (m_acc[i] == 1) m_cd[i] = 3;   // press: outputs in 3 edges
                    m_acc[i]  = raw;
                    m_diff[i] = 0;
                end
            end else begin
                m_diff[i] = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [1:0] exp_state;
        logic       exp_run;
        exp_state = 2'(m_mode);
        exp_run   = (m_mode == 1);
        total++;
        assert (state === exp_state) else begin
            bad++;
            $error("FAIL model_state: got %b want %b at %0t", state, exp_state, $time);
        end
        total++;
        assert (run === exp_run) else begin
            bad++;
            $error("FAIL model_run: got %b want %b at %0t", run, exp_run, $time);
        end
        total++;
        assert (clr_n === m_clr_n) else begin
            bad++;
            $error("FAIL model_clr_n: got %b want %b at %0t", clr_n, m_clr_n, $time);
        end
    endtask

    // One clock: step the model on the edge, then check on the falling edge.
    // Inputs are changed by the caller after tick returns, away from posedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (run === 1'b1) run_seen = 1'b1;
        check_model();
    endtask

    task automatic expect_bits(input string tag, input logic [1:0] got, input logic [1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    task automatic press_release(input bit clr_key, input int hold, input int gap);
        if (clr_key) key_clr_n = 1'b0; else key_ss_n = 1'b0;
        repeat (hold) tick();
        if (clr_key) key_clr_n = 1'b1; else key_ss_n = 1'b1;
        repeat (gap) tick();
    endtask

    initial begin
        model_reset();
        aclr      = 1'b0;
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
        run_seen  = 1'b0;

        // Reset held for 3 cycles, then quiet for 20.
        @(negedge clk);
        repeat (3) tick();
        expect_bits("reset_state", state, 2'b00);
        expect_bits("reset_run",   {1'b0, run},   2'b00);
        expect_bits("reset_clr_n", {1'b0, clr_n}, 2'b01);
        aclr = 1'b1;
        repeat (20) tick();
        expect_bits("idle_state", state, 2'b00);

        // Clean start/stop press: RUNNING exactly 7 edges after the change.
        key_ss_n = 1'b0;
        repeat (6) tick();
        expect_bits("press1_edge6_state", state, 2'b00);
        tick();
        expect_bits("press1_edge7_state", state, 2'b01);
        expect_bits("press1_edge7_run", {1'b0, run}, 2'b01);
        repeat (3) tick();
        key_ss_n = 1'b1;
        repeat (10) tick();
        press_release(1'b0, 10, 10);
        expect_bits("press2_state", state, 2'b10);
        expect_bits("press2_run", {1'b0, run}, 2'b00);
        press_release(1'b0, 10, 10);
        expect_bits("press3_state", state, 2'b01);

        // Bounce: low 3, high 1, low 2, then high. No state change.
        key_ss_n = 1'b0; repeat (3) tick();
        key_ss_n = 1'b1; tick();
        key_ss_n = 1'b0; repeat (2) tick();
        key_ss_n = 1'b1; repeat (12) tick();
        expect_bits("bounce_state", state, 2'b01);
        press_release(1'b0, 10, 10);
        expect_bits("bounce_then_hold_state", state, 2'b10);

        // Clear from RUNNING.
        press_release(1'b0, 10, 10);
        key_clr_n = 1'b0;
        repeat (6) tick();
        expect_bits("clr_edge6_state", state, 2'b01);
        tick();
        expect_bits("clr_edge7_state", state, 2'b00);
        expect_bits("clr_edge7_run", {1'b0, run}, 2'b00);
        expect_bits("clr_edge7_clr_n", {1'b0, clr_n}, 2'b00);
        tick();
        expect_bits("clr_edge8_clr_n", {1'b0, clr_n}, 2'b01);
        repeat (3) tick();
        key_clr_n = 1'b1;
        repeat (10) tick();

        // Clear from IDLE still pulses.
        key_clr_n = 1'b0;
        repeat (7) tick();
        expect_bits("clr_idle_edge7_clr_n", {1'b0, clr_n}, 2'b00);
        tick();
        expect_bits("clr_idle_edge8_clr_n", {1'b0, clr_n}, 2'b01);
        key_clr_n = 1'b1;
        repeat (10) tick();

        // Simultaneous press from PAUSED: clear wins, no RUNNING cycle.
        press_release(1'b0, 10, 10);
        press_release(1'b0, 10, 10);
        expect_bits("sim_pre_state", state, 2'b10);
        run_seen  = 1'b0;
        key_ss_n  = 1'b0;
        key_clr_n = 1'b0;
        repeat (7) tick();
        expect_bits("sim_edge7_state", state, 2'b00);
        expect_bits("sim_edge7_clr_n", {1'b0, clr_n}, 2'b00);
        repeat (10) tick();
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
        repeat (10) tick();
        expect_bits("sim_no_running", {1'b0, run_seen}, 2'b00);

        // Reset mid-debounce with the key still held low.
        key_ss_n = 1'b0;
        repeat (2) tick();
        aclr = 1'b0;
        tick();
        aclr = 1'b1;
        repeat (6) tick();
        expect_bits("rst_mid_edge6_state", state, 2'b00);
        tick();
        expect_bits("rst_mid_edge7_state", state, 2'b01);
        key_ss_n = 1'b1;
        repeat (10) tick();

        // Randomized key activity with occasional resets.
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                aclr = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                aclr = 1'b1;
            end
            key_ss_n  = ($urandom_range(0, 2) != 0);
            key_clr_n = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 12)) tick();
        end
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
